slm_frame_sequencer: RTL and testbench
======================================

// Module: slm_frame_sequencer
// PURPOSE
//  Selects which stored SDRAM image is scanned out to the SLM, replacing the fixed switch-based frame ID.
//  Steps through a configurable image range, holding each image for a fixed number of VGA frames.
//  ID changes happen only on the VGA frame tick, so displayed images never tear.
//  Sits between jtag_uart_decode (config, trigger) and sdram_to_vgafifo (iFRAME_ID); all signals are in the iCLK domain.
// PARAMETERS
//  ID_W   6   frame-ID width; sequence length is 1..2^ID_W
//  CYC_W  16  width of the display-cycles count
//  TRIG_W 8   width of the trigger-pulse length field (optional feature only)
// PORTS
//  iCLK         in  1        clock (SDRAM controller clock)
//  iRST_N       in  1        asynchronous, active-low reset
//  iSTART       in  1        1-cycle pulse: latch config, begin sequence
//  iSTOP        in  1        1-cycle pulse: abort to IDLE
//  iMODE        in  2        0 ONCE, 1 LOOP, 2 PINGPONG, 3 = LOOP
//  iFIRST_ID    in  ID_W     ID of the first image
//  iNUM_FRAMES  in  ID_W+1   number of images N
//  iCYCLES      in  CYC_W    VGA frames per image; 0 is treated as 1
//  iSTATIC_ID   in  ID_W     ID displayed while IDLE
//  iFRAME_TICK  in  1        1-cycle pulse per VGA frame, already synchronised to iCLK
//  iLOAD_OK     in  1        SDRAM image load complete (writer oDONE)
//  iTRIG_LEN    in  TRIG_W   trigger-pulse length in cycles (optional feature only)
//  oFRAME_ID    out ID_W     image to display
//  oFRAME_CHANGE out 1       1-cycle pulse when oFRAME_ID is updated by the sequencer
//  oBUSY        out 1        high in ARM or SHOW
//  oDONE        out 1        1-cycle pulse when a ONCE sequence completes
//  oERR         out 1        1-cycle pulse when a START is rejected
//  oSTATE       out 2        current state encoding, for HEX display
//  oTRIG        out 1        camera trigger (optional feature only)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; direction = up.
//  States:
//    IDLE: oFRAME_ID <= iSTATIC_ID on each iFRAME_TICK.
//    ARM:  waits for the first tick after START.
//    SHOW: sequence is running.
//    HOLD: ONCE mode finished; the last ID is held.
//  START handling:
//    Accepted in any state while iLOAD_OK=1 and N!=0.
//    On acceptance, latch mode, FIRST_ID, N and CYCLES into shadow registers; go to ARM the next cycle.
//    If N > 2^ID_W, clamp N to 2^ID_W.
//    START with N==0 or iLOAD_OK=0: oERR pulses next cycle; state is unchanged.
//    START while busy restarts the sequence from idx 0.
//  ARM -> SHOW on a tick: idx=0, cnt=0, oFRAME_ID=FIRST_ID.
//    oFRAME_CHANGE pulses in the cycle oFRAME_ID updates, one cycle after the tick.
//  SHOW, on each tick:
//    If cnt == CYCLES-1: cnt=0 and advance idx; otherwise cnt++.
//    Each image is therefore displayed for exactly CYCLES frames.
//  Index advance:
//    oFRAME_ID = FIRST_ID + idx, computed modulo 2^ID_W; wrap past the max ID is legal.
//    LOOP: idx = N-1 steps to 0.
//    PINGPONG: idx runs 0..N-1..0; direction flips at each end; end images are not repeated.
//    PINGPONG with N=1: ID stays constant; no further oFRAME_CHANGE pulses.
//    ONCE: when the last image completes, go to HOLD; oDONE pulses; oFRAME_ID is unchanged.
//  HOLD: stays until START, STOP or iLOAD_OK=0.
//  STOP (any state), or iLOAD_OK falling while not IDLE:
//    Go to IDLE the next cycle.
//    oFRAME_ID reverts to iSTATIC_ID at the next tick.
//  Same-cycle priority: STOP > iLOAD_OK low > START > tick.
//  oSTATE encoding: 0 IDLE, 1 ARM, 2 SHOW, 3 HOLD.
// CONFIGURATION
//  SLM_SEQ_CAMERA_TRIG_EN defined:
//    oTRIG goes high in the cycle of each oFRAME_CHANGE.
//    It stays high for max(iTRIG_LEN,1) cycles.
//    A new change during a pulse restarts the pulse.
//  SLM_SEQ_CAMERA_TRIG_EN undefined: oTRIG is tied to 0; iTRIG_LEN is unused; no pulse logic.
// STRUCTURE
//  Shared include slm_seq_defs.vh: state encodings, mode constants (MODE_ONCE/LOOP/PINGPONG).
//  Sub-module slm_trig_pulse: retriggerable pulse stretcher, instantiated only under the macro.
//  Everything else (FSM, tick counter, index stepper) lives in this module.
// TESTING
//  1. LOOP, FIRST_ID=4, N=3, CYC=2, START, ticks:
//     ID sequence 4,4,5,5,6,6,4...; oFRAME_CHANGE every 2nd tick.
//  2. PINGPONG, FIRST_ID=0, N=3, CYC=1:
//     IDs 0,1,2,1,0,1; N=1 gives constant 0 with a single change pulse.
//  3. ONCE, FIRST_ID=62, N=3, CYC=1:
//     IDs 62,63,0; oDONE pulse after the 3rd image; then HOLD with ID 0.
//  4. START with N=0, and START with iLOAD_OK=0: oERR pulse each time; oSTATE stays 0.
//  5. STOP and START in the same cycle while in SHOW: IDLE; at the next tick oFRAME_ID = iSTATIC_ID.
//  6. Reset asserted mid-SHOW: all outputs 0 immediately, asynchronously.
//     With the macro defined: TRIG_LEN=5 gives a 5-cycle oTRIG; TRIG_LEN=0 gives 1 cycle.

Source files
------------

// File: rtl/slm_frame_sequencer_pkg.sv
// Shared definitions for the SLM frame sequencer: state encodings and
// sequence-mode constants used by the top level and the bench.
package slm_frame_sequencer_pkg;

    // State encoding doubles as the oSTATE value shown on the HEX display.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SHOW = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Mode value 3 is not listed here; it behaves as LOOP.
    localparam logic [1:0] MODE_ONCE     = 2'd0;
    localparam logic [1:0] MODE_LOOP     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

endpackage

// File: rtl/slm_trig_pulse.sv
// Retriggerable pulse stretcher for the camera trigger. A fire request
// produces a high output starting the following cycle, lasting
// max(len_i,1) cycles; a new fire during a pulse restarts it.
module slm_trig_pulse #(
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fire_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             pulse_o
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] rem_q, rem_d;
    logic             act_q, act_d;

    // Load the remaining-cycle count on fire, otherwise count the pulse down.
    always_comb begin
        rem_d = rem_q;
        act_d = act_q;
        if (fire_i) begin
            act_d = 1'b1;
            rem_d = (len_i == '0) ? '0 : len_i - ONE;
        end else if (act_q) begin
            if (rem_q == '0) begin
                act_d = 1'b0;
            end else begin
                rem_d = rem_q - ONE;
            end
        end
    end

    // Pulse state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            act_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            act_q <= act_d;
        end
    end

    assign pulse_o = act_q;

endmodule

// File: rtl/slm_frame_sequencer.sv
// SLM frame sequencer: chooses which stored SDRAM image is scanned out,
// stepping through a configured ID range and holding each image for a
// number of VGA frames. ID updates only follow a frame tick so the
// displayed image never tears.
// Optional camera trigger output: define SLM_SEQ_CAMERA_TRIG_EN.
module slm_frame_sequencer
    import slm_frame_sequencer_pkg::*;
#(
    parameter int ID_W   = 6,
    parameter int CYC_W  = 16,
    parameter int TRIG_W = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    input  logic              iSTOP,
    input  logic [1:0]        iMODE,
    input  logic [ID_W-1:0]   iFIRST_ID,
    input  logic [ID_W:0]     iNUM_FRAMES,
    input  logic [CYC_W-1:0]  iCYCLES,
    input  logic [ID_W-1:0]   iSTATIC_ID,
    input  logic              iFRAME_TICK,
    input  logic              iLOAD_OK,
    input  logic [TRIG_W-1:0] iTRIG_LEN,
    output logic [ID_W-1:0]   oFRAME_ID,
    output logic              oFRAME_CHANGE,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR,
    output logic [1:0]        oSTATE,
    output logic              oTRIG
);

    localparam logic [ID_W:0]    N_MAX   = {1'b1, {ID_W{1'b0}}};
    localparam logic [ID_W:0]    N_ONE   = (ID_W+1)'(1);
    localparam logic [ID_W-1:0]  ID_ONE  = ID_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ID_W-1:0]   first_q, first_d;
    logic [ID_W:0]     n_q, n_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [ID_W-1:0]   idx_q, idx_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;      // 0 = counting up, 1 = counting down
    logic [ID_W-1:0]   id_q, id_d;
    logic              chg_q, chg_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ID_W-1:0]   idx_nx;
    logic              dir_nx;
    logic              at_last;

    assign at_last = ({1'b0, idx_q} == (n_q - N_ONE));

    // Index stepper: next image index and direction once the current image completes.
    always_comb begin
        idx_nx = idx_q;
        dir_nx = dir_q;
        case (mode_q)
            MODE_ONCE: begin
                idx_nx = idx_q + ID_ONE;
            end
            MODE_PINGPONG: begin
                if (n_q != N_ONE) begin
                    if (!dir_q) begin
                        if (at_last) begin
                            dir_nx = 1'b1;
                            idx_nx = idx_q - ID_ONE;
                        end else begin
                            idx_nx = idx_q + ID_ONE;
                        end
                    end else begin
                        if (idx_q == '0) begin
                            dir_nx = 1'b0;
                            idx_nx = idx_q + ID_ONE;
                        end else begin
                            idx_nx = idx_q - ID_ONE;
                        end
                    end
                end
            end
            default: begin
                idx_nx = at_last ? '0 : idx_q + ID_ONE;
            end
        endcase
    end

    // Sequencer FSM: control priority STOP > load lost > START > frame tick.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        first_d = first_q;
        n_d     = n_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        id_d    = id_q;
        chg_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (iSTOP) begin
            state_d = ST_IDLE;
        end else if (!iLOAD_OK && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            err_d   = iSTART;
        end else if (iSTART && iLOAD_OK && iNUM_FRAMES != '0) begin
            state_d = ST_ARM;
            mode_d  = iMODE;
            first_d = iFIRST_ID;
            n_d     = (iNUM_FRAMES > N_MAX) ? N_MAX : iNUM_FRAMES;
            cyc_d   = (iCYCLES == '0) ? CYC_ONE : iCYCLES;
        end else begin
            // Any START reaching this branch was rejected.
            err_d = iSTART;
            if (iFRAME_TICK) begin
                case (state_q)
                    ST_IDLE: id_d = iSTATIC_ID;
                    ST_ARM: begin
                        state_d = ST_SHOW;
                        idx_d   = '0;
                        cnt_d   = '0;
                        dir_d   = 1'b0;
                        id_d    = first_q;
                        chg_d   = 1'b1;
                    end
                    ST_SHOW: begin
                        if (cnt_q == cyc_q - CYC_ONE) begin
                            cnt_d = '0;
                            if (mode_q == MODE_ONCE && at_last) begin
                                state_d = ST_HOLD;
                                done_d  = 1'b1;
                            end else begin
                                idx_d = idx_nx;
                                dir_d = dir_nx;
                                id_d  = first_q + idx_nx;
                                chg_d = (idx_nx != idx_q);
                            end
                        end else begin
                            cnt_d = cnt_q + CYC_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, shadow configuration and output registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            first_q <= '0;
            n_q     <= '0;
            cyc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            id_q    <= '0;
            chg_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            first_q <= first_d;
            n_q     <= n_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            id_q    <= id_d;
            chg_q   <= chg_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign oFRAME_ID     = id_q;
    assign oFRAME_CHANGE = chg_q;
    assign oBUSY         = (state_q == ST_ARM) || (state_q == ST_SHOW);
    assign oDONE         = done_q;
    assign oERR          = err_q;
    assign oSTATE        = state_q;

`ifdef SLM_SEQ_CAMERA_TRIG_EN
    // Fed from the next-state change flag so oTRIG rises with oFRAME_CHANGE.
    slm_trig_pulse #(
        .LEN_W (TRIG_W)
    ) u_trig_pulse (
        .clk_i   (iCLK),
        .rst_ni  (iRST_N),
        .fire_i  (chg_d),
        .len_i   (iTRIG_LEN),
        .pulse_o (oTRIG)
    );
`else
    logic unused_trig_len;
    assign unused_trig_len = ^iTRIG_LEN;
    assign oTRIG = 1'b0;
`endif

endmodule

// File: tb/tb_slm_frame_sequencer.sv
// Directed bench for slm_frame_sequencer with hand-computed expectations.
module tb_slm_frame_sequencer;

    localparam int ID_W   = 6;
    localparam int CYC_W  = 16;
    localparam int TRIG_W = 8;

    logic              iCLK = 1'b0;
    logic              iRST_N = 1'b0;
    logic              iSTART = 1'b0;
    logic              iSTOP = 1'b0;
    logic [1:0]        iMODE = 2'd0;
    logic [ID_W-1:0]   iFIRST_ID = '0;
    logic [ID_W:0]     iNUM_FRAMES = '0;
    logic [CYC_W-1:0]  iCYCLES = '0;
    logic [ID_W-1:0]   iSTATIC_ID = '0;
    logic              iFRAME_TICK = 1'b0;
    logic              iLOAD_OK = 1'b0;
    logic [TRIG_W-1:0] iTRIG_LEN = '0;
    logic [ID_W-1:0]   oFRAME_ID;
    logic              oFRAME_CHANGE;
    logic              oBUSY;
    logic              oDONE;
    logic              oERR;
    logic [1:0]        oSTATE;
    logic              oTRIG;

    int total = 0;
    int bad   = 0;

    int loop_id[7]  = '{4, 4, 5, 5, 6, 6, 4};
    int loop_chg[7] = '{1, 0, 1, 0, 1, 0, 1};
    int pp_id[6]    = '{0, 1, 2, 1, 0, 1};

    slm_frame_sequencer #(
        .ID_W   (ID_W),
        .CYC_W  (CYC_W),
        .TRIG_W (TRIG_W)
    ) dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .iSTART        (iSTART),
        .iSTOP         (iSTOP),
        .iMODE         (iMODE),
        .iFIRST_ID     (iFIRST_ID),
        .iNUM_FRAMES   (iNUM_FRAMES),
        .iCYCLES       (iCYCLES),
        .iSTATIC_ID    (iSTATIC_ID),
        .iFRAME_TICK   (iFRAME_TICK),
        .iLOAD_OK      (iLOAD_OK),
        .iTRIG_LEN     (iTRIG_LEN),
        .oFRAME_ID     (oFRAME_ID),
        .oFRAME_CHANGE (oFRAME_CHANGE),
        .oBUSY         (oBUSY),
        .oDONE         (oDONE),
        .oERR          (oERR),
        .oSTATE        (oSTATE),
        .oTRIG         (oTRIG)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic tick();
        iFRAME_TICK = 1'b1;
        step();
        iFRAME_TICK = 1'b0;
    endtask

    task automatic start(input logic [1:0] m, input int first, input int n, input int cyc);
        iMODE       = m;
        iFIRST_ID   = ID_W'(first);
        iNUM_FRAMES = (ID_W+1)'(n);
        iCYCLES     = CYC_W'(cyc);
        iSTART      = 1'b1;
        step();
        iSTART      = 1'b0;
    endtask

`ifdef SLM_SEQ_CAMERA_TRIG_EN
    task automatic trig_len(input int len, input int exp);
        int hi;
        hi = 0;
        iTRIG_LEN = TRIG_W'(len);
        start(2'd1, 0, 2, 1);
        tick();
        for (int i = 0; i < 20 && oTRIG; i++) begin
            hi++;
            step();
        end
        chk("trig_len", 32'(hi), 32'(exp));
    endtask
`endif

    initial begin
        // reset state
        #2;
        chk("rst_id", 32'(oFRAME_ID), 0);
        chk("rst_state", 32'(oSTATE), 0);
        chk("rst_busy", 32'(oBUSY), 0);
        step();
        step();
        iRST_N   = 1'b1;
        iLOAD_OK = 1'b1;
        iSTATIC_ID = 6'd9;
        step();

        // LOOP FIRST_ID=4 N=3 CYC=2
        start(2'd1, 4, 3, 2);
        chk("loop_arm_state", 32'(oSTATE), 1);
        chk("loop_arm_busy", 32'(oBUSY), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("loop_id", 32'(oFRAME_ID), 32'(loop_id[i]));
            chk("loop_chg", 32'(oFRAME_CHANGE), 32'(loop_chg[i]));
`ifndef SLM_SEQ_CAMERA_TRIG_EN
            chk("trig_off", 32'(oTRIG), 0);
`endif
            step();
            chk("loop_chg_drop", 32'(oFRAME_CHANGE), 0);
        end
        chk("loop_state", 32'(oSTATE), 2);

        // PINGPONG FIRST_ID=0 N=3 CYC=1, restarted while busy
        start(2'd2, 0, 3, 1);
        chk("pp_restart_state", 32'(oSTATE), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pp_id", 32'(oFRAME_ID), 32'(pp_id[i]));
            chk("pp_chg", 32'(oFRAME_CHANGE), 1);
        end

        // PINGPONG N=1: constant ID, single change pulse
        start(2'd2, 0, 1, 1);
        tick();
        chk("pp1_id0", 32'(oFRAME_ID), 0);
        chk("pp1_chg0", 32'(oFRAME_CHANGE), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pp1_id", 32'(oFRAME_ID), 0);
            chk("pp1_chg", 32'(oFRAME_CHANGE), 0);
        end

        // PINGPONG with N=65 clamps to 64, CYCLES=0 acts as 1
        start(2'd2, 0, 65, 0);
        for (int i = 0; i < 64; i++) tick();
        chk("clamp_top", 32'(oFRAME_ID), 63);
        tick();
        chk("clamp_turn", 32'(oFRAME_ID), 62);

        // ONCE FIRST_ID=62 N=3 CYC=1 with ID wrap
        start(2'd0, 62, 3, 1);
        tick();
        chk("once_id0", 32'(oFRAME_ID), 62);
        tick();
        chk("once_id1", 32'(oFRAME_ID), 63);
        tick();
        chk("once_id2", 32'(oFRAME_ID), 0);
        chk("once_done_early", 32'(oDONE), 0);
        tick();
        chk("once_done", 32'(oDONE), 1);
        chk("once_hold_state", 32'(oSTATE), 3);
        chk("once_hold_id", 32'(oFRAME_ID), 0);
        chk("once_hold_chg", 32'(oFRAME_CHANGE), 0);
        chk("once_hold_busy", 32'(oBUSY), 0);
        step();
        chk("once_done_drop", 32'(oDONE), 0);
        tick();
        chk("hold_stays", 32'(oSTATE), 3);
        chk("hold_id", 32'(oFRAME_ID), 0);

        // STOP from HOLD, static ID on next tick
        iSTOP = 1'b1;
        step();
        iSTOP = 1'b0;
        chk("stop_state", 32'(oSTATE), 0);
        tick();
        chk("idle_static", 32'(oFRAME_ID), 9);
        chk("idle_chg", 32'(oFRAME_CHANGE), 0);

        // rejected STARTs
        start(2'd1, 3, 0, 1);
        chk("err_n0", 32'(oERR), 1);
        chk("err_n0_state", 32'(oSTATE), 0);
        step();
        chk("err_drop", 32'(oERR), 0);
        iLOAD_OK = 1'b0;
        start(2'd1, 3, 2, 1);
        chk("err_load", 32'(oERR), 1);
        chk("err_load_state", 32'(oSTATE), 0);
        iLOAD_OK = 1'b1;
        step();

        // STOP and START together while in SHOW
        start(2'd1, 10, 2, 1);
        tick();
        chk("ss_show", 32'(oSTATE), 2);
        chk("ss_id", 32'(oFRAME_ID), 10);
        iSTOP = 1'b1;
        start(2'd1, 20, 2, 1);
        iSTOP = 1'b0;
        chk("ss_state", 32'(oSTATE), 0);
        chk("ss_err", 32'(oERR), 0);
        chk("ss_id_kept", 32'(oFRAME_ID), 10);
        tick();
        chk("ss_static", 32'(oFRAME_ID), 9);

        // load lost while in SHOW
        start(2'd1, 5, 2, 1);
        tick();
        iLOAD_OK = 1'b0;
        step();
        chk("loadlost_state", 32'(oSTATE), 0);
        iLOAD_OK = 1'b1;
        step();

`ifdef SLM_SEQ_CAMERA_TRIG_EN
        trig_len(5, 5);
        trig_len(0, 1);
`endif

        // asynchronous reset mid-SHOW
        start(2'd1, 7, 3, 1);
        tick();
        tick();
        chk("pre_rst_id", 32'(oFRAME_ID), 8);
        iRST_N = 1'b0;
        #1;
        chk("arst_id", 32'(oFRAME_ID), 0);
        chk("arst_state", 32'(oSTATE), 0);
        chk("arst_busy", 32'(oBUSY), 0);
        chk("arst_chg", 32'(oFRAME_CHANGE), 0);
        chk("arst_trig", 32'(oTRIG), 0);
        step();
        iRST_N = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
